// File: rtl/stream_accumulator.sv
// Burst accumulator that folds iLen operands through a carry-select adder.
// Optional ACC_CARRY_COUNT_EN adds a saturating carry counter (oCarryCnt).

module carry_chain_adder #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);
  localparam int NB = WIDTH / BLOCK_WIDTH;

  logic [NB:0] c_w;

  assign c_w[0] = iC;

  // Each block precomputes both carry-in cases; the chain only muxes.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLOCK_WIDTH:0] s0_w;
    logic [BLOCK_WIDTH:0] s1_w;

    assign s0_w = {1'b0, iA[g*BLOCK_WIDTH +: BLOCK_WIDTH]}
                + {1'b0, iB[g*BLOCK_WIDTH +: BLOCK_WIDTH]};
    assign s1_w = s0_w + {{BLOCK_WIDTH{1'b0}}, 1'b1};

    assign oS[g*BLOCK_WIDTH +: BLOCK_WIDTH] =
      c_w[g] ? s1_w[BLOCK_WIDTH-1:0] : s0_w[BLOCK_WIDTH-1:0];
    assign c_w[g+1] = c_w[g] ? s1_w[BLOCK_WIDTH] : s0_w[BLOCK_WIDTH];
  end

  assign oC = c_w[NB];
endmodule

module stream_accumulator #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic [COUNT_WIDTH-1:0] iLen,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [WIDTH-1:0]       iD,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [WIDTH-1:0]       oSum,
  output logic                   oOverflow,
  output logic                   oBusy
`ifdef ACC_CARRY_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] oCarryCnt
`endif
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [WIDTH-1:0]       add_s;
  logic                   add_c;

  carry_chain_adder #(
    .WIDTH      (WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_add (
    .iA(acc_q),
    .iB(iD),
    .iC(1'b0),
    .oS(add_s),
    .oC(add_c)
  );

`ifdef ACC_CARRY_COUNT_EN
  logic [COUNT_WIDTH-1:0] ccnt_q, ccnt_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef ACC_CARRY_COUNT_EN
    ccnt_d  = ccnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = iLen;
`ifdef ACC_CARRY_COUNT_EN
          ccnt_d  = '0;
`endif
          state_d = (iLen == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (iValid) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_c;
          cnt_d = cnt_q - 1'b1;
`ifdef ACC_CARRY_COUNT_EN
          if (add_c && (ccnt_q != '1))
            ccnt_d = ccnt_q + 1'b1;
`endif
          if (cnt_q == COUNT_WIDTH'(1))
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (iReady)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ACC_CARRY_COUNT_EN
  always_ff @(posedge iClk) begin
    if (iRst)
      ccnt_q <= '0;
    else
      ccnt_q <= ccnt_d;
  end

  assign oCarryCnt = ccnt_q;
`endif

  assign oReady    = (state_q == S_ACC);
  assign oValid    = (state_q == S_DONE);
  assign oBusy     = (state_q != S_IDLE);
  assign oSum      = acc_q;
  assign oOverflow = ovf_q;
endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench for stream_accumulator with an exact-sum reference model.
// Checks oCarryCnt too when ACC_CARRY_COUNT_EN is defined.

module tb_stream_accumulator;
  localparam int W  = 32;
  localparam int CW = 8;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [CW-1:0] iLen;
  logic          iValid;
  logic          oReady;
  logic [W-1:0]  iD;
  logic          oValid;
  logic          iReady;
  logic [W-1:0]  oSum;
  logic          oOverflow;
  logic          oBusy;
`ifdef ACC_CARRY_COUNT_EN
  logic [CW-1:0] oCarryCnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  stream_accumulator #(
    .WIDTH      (W),
    .BLOCK_WIDTH(8),
    .COUNT_WIDTH(CW)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iStart   (iStart),
    .iLen     (iLen),
    .iValid   (iValid),
    .oReady   (oReady),
    .iD       (iD),
    .oValid   (oValid),
    .iReady   (iReady),
    .oSum     (oSum),
    .oOverflow(oOverflow),
    .oBusy    (oBusy)
`ifdef ACC_CARRY_COUNT_EN
    ,
    .oCarryCnt(oCarryCnt)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 collecting, 2 result held.
  // m_ext is the exact (unwrapped) sum of the burst.
  int              m_phase = 0;
  int              m_left  = 0;
  longint unsigned m_ext   = 0;
  bit              m_live  = 0;

  always @(posedge iClk) begin
    if (iRst) begin
      m_phase = 0;
      m_ext   = 0;
      m_live  = 1;
    end else begin
      case (m_phase)
        0: if (iStart) begin
          m_ext   = 0;
          m_left  = int'(iLen);
          m_phase = (m_left == 0) ? 2 : 1;
        end
        1: if (iValid) begin
          m_ext  = m_ext + longint'(iD);
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (iReady) m_phase = 0;
      endcase
    end
  end

  always @(negedge iClk) begin
    if (m_live) begin
      chk("ready", 64'(oReady), 64'(m_phase == 1));
      chk("valid", 64'(oValid), 64'(m_phase == 2));
      chk("busy", 64'(oBusy), 64'(m_phase != 0));
      chk("sum", 64'(oSum), m_ext & 64'hFFFF_FFFF);
      chk("ovf", 64'(oOverflow), 64'((m_ext >> 32) != 0));
`ifdef ACC_CARRY_COUNT_EN
      chk("ccnt", 64'(oCarryCnt),
          ((m_ext >> 32) > 255) ? 64'd255 : (m_ext >> 32));
`endif
    end
  end

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic start(input int len);
    iStart = 1'b1;
    iLen   = CW'(len);
    tick();
    iStart = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d);
    iValid = 1'b1;
    iD     = d;
    tick();
    iValid = 1'b0;
  endtask

  task automatic expect_res(input string nm, input logic [W-1:0] s,
                            input logic o, input int cc);
    chk({nm, "_valid"}, 64'(oValid), 64'd1);
    chk({nm, "_sum"}, 64'(oSum), 64'(s));
    chk({nm, "_ovf"}, 64'(oOverflow), 64'(o));
`ifdef ACC_CARRY_COUNT_EN
    chk({nm, "_ccnt"}, 64'(oCarryCnt), 64'(cc));
`else
    if (cc < 0) chk({nm, "_cc"}, 64'(cc), 64'd0);
`endif
  endtask

  task automatic release_res();
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  initial begin
    iRst   = 1'b1;
    iStart = 1'b0;
    iLen   = '0;
    iValid = 1'b0;
    iD     = '0;
    iReady = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
    chk("rst_sum", 64'(oSum), 64'd0);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_ready", 64'(oReady), 64'd0);

    // 1..4 held valid: result the cycle after the 4th beat
    start(4);
    for (int i = 1; i <= 4; i++) beat(W'(i));
    expect_res("b4", 32'd10, 1'b0, 0);
    release_res();

    // wrap with a single carry
    start(3);
    beat(32'hFFFF_FFFF);
    beat(32'h0000_0002);
    beat(32'h8000_0000);
    expect_res("wrap", 32'h8000_0001, 1'b1, 1);
    release_res();

    // empty burst
    start(0);
    chk("len0_ready", 64'(oReady), 64'd0);
    expect_res("len0", 32'd0, 1'b0, 0);
    release_res();

    // gapped valid, then stall with ignored iStart
    start(3);
    beat(32'd5);
    tick();
    tick();
    beat(32'd6);
    beat(32'd7);
    expect_res("gap", 32'd18, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      iStart = (i == 2);
      iLen   = 8'd2;
      tick();
      chk("hold_valid", 64'(oValid), 64'd1);
      chk("hold_sum", 64'(oSum), 64'd18);
    end
    iStart = 1'b1;
    iLen   = 8'd1;
    release_res();
    iStart = 1'b0;
    chk("hs_start_ign", 64'(oBusy), 64'd0);

    // reset mid-burst
    start(4);
    beat(32'd1);
    beat(32'd2);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("mrst_sum", 64'(oSum), 64'd0);
    chk("mrst_busy", 64'(oBusy), 64'd0);
    chk("mrst_ready", 64'(oReady), 64'd0);
    start(1);
    beat(32'd7);
    expect_res("post_rst", 32'd7, 1'b0, 0);
    release_res();

    // back-to-back with iReady tied high
    iReady = 1'b1;
    start(2);
    beat(32'hFFFF_FFFF);
    beat(32'h0000_0001);
    expect_res("bb0", 32'd0, 1'b1, 1);
    tick();
    start(1);
    beat(32'd5);
    expect_res("bb1", 32'd5, 1'b0, 0);
    tick();
    start(1);
    beat(32'd9);
    expect_res("bb2", 32'd9, 1'b0, 0);
    tick();
    iReady = 1'b0;

    // maximum length: exactly 255 beats
    start(255);
    for (int i = 1; i <= 255; i++) beat(W'(i));
    expect_res("max", 32'd32640, 1'b0, 0);
    release_res();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
